// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter.
// FSM states, pattern_sel codes and the RGB565 colour-bar palette.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACT,
    ST_HBLK,
    ST_VFP
  } state_t;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_INDEX   = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_tx_pattern.sv
// Test-pattern pixel source: pixel column, line parity and pattern select in,
// registered RGB565 pixel out one clock later.
module dvp_tx_pattern
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [14:0] x,
  input  logic        y_bit3,
  input  logic        frame_start,
  input  logic        line_done,
  output logic [15:0] pix
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [15:0] line_base_reg;
  logic [15:0] pix_reg;
  logic [15:0] pix_next;
  logic [15:0] x_ext;
  logic [6:0]  bar_hit;
  logic [2:0]  bar_idx;

  // Thermometer of bar boundaries; the last bar keeps every column past 7*BAR_W.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar
      assign bar_hit[gi] = (x >= 15'((gi + 1) * BAR_W));
    end
  endgenerate

  always_comb begin
    x_ext    = 16'(x);
    bar_idx  = 3'($countones(bar_hit));
    pix_next = 16'h0000;
    case (sel)
      PAT_BARS:    pix_next = bar_colour(bar_idx);
      PAT_RAMP:    pix_next = {x_ext[4:0], x_ext[5:0], x_ext[4:0]};
      PAT_CHECKER: pix_next = (x_ext[3] ^ y_bit3) ? 16'hFFFF : 16'h0000;
      default:     pix_next = line_base_reg + x_ext;
    endcase
  end

  // line_base_reg tracks y*H_ACTIVE by accumulation so the index pattern needs no multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base_reg <= '0;
      pix_reg       <= '0;
    end else begin
      if (frame_start) begin
        line_base_reg <= '0;
      end else if (line_done) begin
        line_base_reg <= line_base_reg + 16'(H_ACTIVE);
      end
      pix_reg <= pix_next;
    end
  end

  assign pix = pix_reg;

endmodule

// File: rtl/dvp_frame_gen.sv
// OV5640-style DVP transmitter: frame timing FSM, byte mux and frame counter.
// Optional DVP_TX_FRAME_TAG_EN replaces pixel (0,0) with the frame number.
module dvp_frame_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 160,
  parameter int VSYNC_LINES = 4,
  parameter int V_BP        = 2,
  parameter int V_FP        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LT = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] H_LAST   = 16'(LT - 1);
  localparam logic [15:0] ACT_LAST = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VBP_LAST = 16'(V_BP - 1);
  localparam logic [15:0] VA_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VFP_LAST = 16'(V_FP - 1);

  // Zero-length vertical phases are skipped entirely.
  localparam state_t AFTER_VBP   = ST_ACT;
  localparam state_t AFTER_VSYNC = (V_BP > 0) ? ST_VBP : AFTER_VBP;
  localparam state_t FIRST_STATE = (VSYNC_LINES > 0) ? ST_VSYNC : AFTER_VSYNC;

  state_t      state_reg, state_next;
  logic [15:0] h_cnt_reg, h_cnt_next;
  logic [15:0] line_cnt_reg, line_cnt_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0]  sel_reg;
  logic        h_wrap;
  logic        frame_end;
  logic        frame_start;
  logic        line_done;

  logic        cam_vsync_reg;
  logic        cam_href_reg;
  logic        byte_lo_reg;
  logic        frame_done_reg;

  logic [15:0] pat_pix;
  logic [15:0] pixel;

  always_comb begin
    state_next    = state_reg;
    h_cnt_next    = h_cnt_reg + 16'd1;
    line_cnt_next = line_cnt_reg;
    frame_end     = 1'b0;
    frame_start   = 1'b0;
    line_done     = 1'b0;
    h_wrap        = (h_cnt_reg == H_LAST);

    case (state_reg)
      ST_IDLE: begin
        h_cnt_next = '0;
        if (enable) begin
          state_next  = FIRST_STATE;
          frame_start = 1'b1;
        end
      end
      ST_VSYNC: begin
        if (h_wrap) begin
          h_cnt_next = '0;
          if (line_cnt_reg == VS_LAST) begin
            line_cnt_next = '0;
            state_next    = AFTER_VSYNC;
          end else begin
            line_cnt_next = line_cnt_reg + 16'd1;
          end
        end
      end
      ST_VBP: begin
        if (h_wrap) begin
          h_cnt_next = '0;
          if (line_cnt_reg == VBP_LAST) begin
            line_cnt_next = '0;
            state_next    = AFTER_VBP;
          end else begin
            line_cnt_next = line_cnt_reg + 16'd1;
          end
        end
      end
      ST_ACT: begin
        if (h_cnt_reg == ACT_LAST) begin
          state_next = ST_HBLK;
        end
      end
      ST_HBLK: begin
        if (h_wrap) begin
          h_cnt_next = '0;
          line_done  = 1'b1;
          if (line_cnt_reg == VA_LAST) begin
            line_cnt_next = '0;
            if (V_FP > 0) begin
              state_next = ST_VFP;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            line_cnt_next = line_cnt_reg + 16'd1;
            state_next    = ST_ACT;
          end
        end
      end
      ST_VFP: begin
        if (h_wrap) begin
          h_cnt_next = '0;
          if (line_cnt_reg == VFP_LAST) begin
            frame_end = 1'b1;
          end else begin
            line_cnt_next = line_cnt_reg + 16'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        h_cnt_next = '0;
      end
    endcase

    // enable is only consulted at frame boundaries, so frames are never truncated.
    if (frame_end) begin
      line_cnt_next = '0;
      frame_start   = enable;
      state_next    = enable ? FIRST_STATE : ST_IDLE;
    end

    frame_cnt_next = frame_cnt_reg + 16'(frame_end);
  end

  // Outputs are registered from the current state, one clock behind the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      h_cnt_reg      <= '0;
      line_cnt_reg   <= '0;
      frame_cnt_reg  <= '0;
      sel_reg        <= PAT_BARS;
      cam_vsync_reg  <= 1'b0;
      cam_href_reg   <= 1'b0;
      byte_lo_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      h_cnt_reg      <= h_cnt_next;
      line_cnt_reg   <= line_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      if (frame_start) begin
        sel_reg <= pattern_sel;
      end
      cam_vsync_reg  <= (state_reg == ST_VSYNC);
      cam_href_reg   <= (state_reg == ST_ACT);
      byte_lo_reg    <= h_cnt_reg[0];
      frame_done_reg <= frame_end;
    end
  end

  dvp_tx_pattern #(
    .H_ACTIVE(H_ACTIVE)
  ) u_pattern (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel_reg),
    .x          (h_cnt_reg[15:1]),
    .y_bit3     (line_cnt_reg[3]),
    .frame_start(frame_start),
    .line_done  (line_done),
    .pix        (pat_pix)
  );

`ifdef DVP_TX_FRAME_TAG_EN
  logic [15:0] tag_reg;
  logic        first_pix_reg;

  // The tag is the post-increment count, i.e. the number of frames completed before this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg       <= '0;
      first_pix_reg <= 1'b0;
    end else begin
      if (frame_start) begin
        tag_reg <= frame_cnt_next;
      end
      first_pix_reg <= (state_reg == ST_ACT) && (h_cnt_reg[15:1] == '0) && (line_cnt_reg == '0);
    end
  end

  assign pixel = first_pix_reg ? tag_reg : pat_pix;
`else
  assign pixel = pat_pix;
`endif

  assign cam_vsync  = cam_vsync_reg;
  assign cam_href   = cam_href_reg;
  assign cam_data   = cam_href_reg ? (byte_lo_reg ? pixel[7:0] : pixel[15:8]) : 8'h00;
  assign frame_done = frame_done_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule
